// File: rtl/cpu_pkg.sv
// Shared types and constants for the fetch front-end and its branch-select helpers.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] INSTR_BYTES      = 32'd4;

endpackage

// File: rtl/branch_target_calc.sv
// Both next-PC candidates for the branch mux: sequential pc+4 and the branch target.
module branch_target_calc
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic [ADDR_W-1:0] br_offset,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [ADDR_W-1:0] branch_target
);

  // Word offset becomes a byte offset; the two top bits fall off and the add wraps.
  assign pc_plus4      = pc + ADDR_W'(INSTR_BYTES);
  assign branch_target = br_pc + (br_offset << 2);

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter owner: fetches one instruction at a time, holds it for decode,
// and redirects on a taken branch.
module fetch_pc_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_accept,
  input  logic              resolve_valid,
  input  logic              branch,
  input  logic              zero,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic [ADDR_W-1:0] br_offset,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [ADDR_W-1:0] branch_target
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              instr_valid_q, instr_valid_d;
  logic              taken;

  branch_target_calc #(.ADDR_W(ADDR_W)) u_calc (
    .pc           (pc_q),
    .br_pc        (br_pc),
    .br_offset    (br_offset),
    .pc_plus4     (pc_plus4),
    .branch_target(branch_target)
  );

  assign taken = resolve_valid & branch & zero;

  always_comb begin
    // NOTE: every _d starts at its _q so no path leaves a value unassigned (no latches).
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;

    unique case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: if (imem_ready) begin
        instr_d       = imem_rdata;
        instr_pc_d    = pc_q;
        instr_valid_d = 1'b1;
        pc_d          = pc_plus4;
        state_d       = HOLD;
      end
      HOLD:  if (instr_accept) begin
        instr_valid_d = 1'b0;
        state_d       = FETCH;
      end
      default: state_d = IDLE;
    endcase

    // A taken branch wins over everything, including a word returning this cycle.
    if (taken) begin
      pc_d          = branch_target;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = 1'b0;
      state_d       = FETCH;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment; reset is sampled on the edge only.
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench: two units (default and wrapping reset PC) against a behavioural model.
module tb_fetch_pc_unit;

  localparam logic [31:0] RP0 = 32'h0000_0000;
  localparam logic [31:0] RP1 = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst_n, imem_ready, instr_accept, resolve_valid, branch, zero;
  logic [31:0] imem_rdata, br_pc, br_offset;

  logic        d0_req, d0_valid, d1_req, d1_valid;
  logic [31:0] d0_addr, d0_instr, d0_ipc, d0_p4, d0_bt;
  logic [31:0] d1_addr, d1_instr, d1_ipc, d1_p4, d1_bt;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  fetch_pc_unit #(.RESET_PC(RP0)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(d0_req), .imem_addr(d0_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(d0_instr),
    .instr_pc(d0_ipc), .instr_valid(d0_valid), .instr_accept(instr_accept),
    .resolve_valid(resolve_valid), .branch(branch), .zero(zero),
    .br_pc(br_pc), .br_offset(br_offset), .pc_plus4(d0_p4), .branch_target(d0_bt)
  );

  fetch_pc_unit #(.RESET_PC(RP1)) dut_w (
    .clk(clk), .rst_n(rst_n), .imem_req(d1_req), .imem_addr(d1_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(d1_instr),
    .instr_pc(d1_ipc), .instr_valid(d1_valid), .instr_accept(instr_accept),
    .resolve_valid(resolve_valid), .branch(branch), .zero(zero),
    .br_pc(br_pc), .br_offset(br_offset), .pc_plus4(d1_p4), .branch_target(d1_bt)
  );

  // Model: "starting" = one dead cycle after reset, "fetching" = request out,
  // "valid" = a word is held for decode.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] ipc;
    bit          valid;
    bit          fetching;
    bit          starting;
  } mdl_t;

  mdl_t m0, m1;

  function automatic mdl_t step(mdl_t m, logic [31:0] rp);
    mdl_t r = m;
    logic [31:0] tgt = br_pc + br_offset * 32'd4;
    if (!rst_n) begin
      r.pc = rp; r.instr = 0; r.ipc = 0;
      r.valid = 0; r.fetching = 0; r.starting = 1;
    end else if (resolve_valid && branch && zero) begin
      r.pc = tgt; r.valid = 0; r.fetching = 1; r.starting = 0;
    end else if (m.starting) begin
      r.starting = 0; r.fetching = 1;
    end else if (m.fetching && imem_ready) begin
      r.instr = imem_rdata; r.ipc = m.pc; r.valid = 1;
      r.pc = m.pc + 32'd4; r.fetching = 0;
    end else if (m.valid && instr_accept) begin
      r.valid = 0; r.fetching = 1;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_unit(input string p, input mdl_t m, input logic req,
                            input logic [31:0] addr, input logic valid,
                            input logic [31:0] ins, input logic [31:0] ipc,
                            input logic [31:0] p4, input logic [31:0] bt);
    check({p, "_req"}, 32'(req), 32'(m.fetching));
    if (m.fetching) check({p, "_addr"}, addr, m.pc);
    check({p, "_valid"}, 32'(valid), 32'(m.valid));
    check({p, "_instr"}, ins, m.instr);
    check({p, "_instr_pc"}, ipc, m.ipc);
    check({p, "_pc_plus4"}, p4, m.pc + 32'd4);
    check({p, "_branch_target"}, bt, br_pc + br_offset * 32'd4);
  endtask

  // One clock: model steps on the edge, DUTs are compared on the falling edge.
  task automatic cycle();
    @(posedge clk);
    m0 = step(m0, RP0);
    m1 = step(m1, RP1);
    @(negedge clk);
    check_unit("d0", m0, d0_req, d0_addr, d0_valid, d0_instr, d0_ipc, d0_p4, d0_bt);
    check_unit("d1", m1, d1_req, d1_addr, d1_valid, d1_instr, d1_ipc, d1_p4, d1_bt);
    imem_rdata = $urandom;
  endtask

  initial begin
    rst_n = 0; imem_ready = 0; instr_accept = 0; resolve_valid = 0;
    branch = 0; zero = 0; br_pc = 0; br_offset = 0; imem_rdata = $urandom;
    m0 = '{default: 0}; m1 = '{default: 0};

    cycle();
    check("rst_req", 32'(d0_req), 0);
    check("rst_valid", 32'(d0_valid), 0);
    check("rst_pc_plus4", d0_p4, 32'h4);

    // Streaming with memory and decode always ready.
    rst_n = 1; imem_ready = 1; instr_accept = 1;
    cycle();
    check("first_addr", d0_addr, 32'h0);
    check("first_req", 32'(d0_req), 1);
    check("wrap_first_addr", d1_addr, 32'hFFFF_FFFC);
    cycle();
    check("hold_instr_pc", d0_ipc, 32'h0);
    cycle();
    check("second_addr", d0_addr, 32'h4);
    check("wrap_second_addr", d1_addr, 32'h0);
    cycle();
    cycle();
    check("third_addr", d0_addr, 32'h8);

    // Memory stall at pc=0x8.
    imem_ready = 0;
    repeat (3) begin
      cycle();
      check("stall_req", 32'(d0_req), 1);
      check("stall_addr", d0_addr, 32'h8);
    end
    imem_ready = 1; instr_accept = 0;
    cycle();
    check("stall_valid", 32'(d0_valid), 1);
    check("stall_instr_pc", d0_ipc, 32'h8);

    // Decode back-pressure.
    repeat (4) begin
      cycle();
      check("bp_valid", 32'(d0_valid), 1);
      check("bp_instr_pc", d0_ipc, 32'h8);
      check("bp_req", 32'(d0_req), 0);
      check("bp_pc_plus4", d0_p4, 32'h10);
    end

    // Taken branch while holding.
    resolve_valid = 1; branch = 1; zero = 1; br_pc = 32'h10; br_offset = 32'd3;
    #1 check("bt_value", d0_bt, 32'h1C);
    cycle();
    check("taken_valid", 32'(d0_valid), 0);
    check("taken_addr", d0_addr, 32'h1C);
    resolve_valid = 0;

    // Not taken: zero=0.
    cycle();
    check("nt_hold_pc", d0_ipc, 32'h1C);
    resolve_valid = 1; branch = 1; zero = 0; instr_accept = 1;
    cycle();
    check("nt_zero_addr", d0_addr, 32'h20);

    // Not taken: branch=0.
    branch = 0; zero = 1; instr_accept = 0;
    cycle();
    check("nt_br_valid", 32'(d0_valid), 1);
    instr_accept = 1;
    cycle();
    check("nt_br_addr", d0_addr, 32'h24);

    // Reset while holding, observed on the wrapping unit.
    resolve_valid = 0; instr_accept = 0;
    cycle();
    check("pre_rst_valid", 32'(d1_valid), 1);
    rst_n = 0;
    cycle();
    check("mid_rst_valid", 32'(d1_valid), 0);
    check("mid_rst_req", 32'(d1_req), 0);
    check("mid_rst_pc_plus4", d1_p4, 32'h0);
    rst_n = 1;

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rst_n         = ($urandom_range(0, 99) != 0);
      imem_ready    = ($urandom_range(0, 9) < 6);
      instr_accept  = ($urandom_range(0, 1) == 1);
      resolve_valid = ($urandom_range(0, 9) < 3);
      branch        = ($urandom_range(0, 3) != 0);
      zero          = ($urandom_range(0, 3) != 0);
      br_pc         = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00} & 32'hFFFF_FFFC;
      br_offset     = ($urandom_range(0, 1) == 1) ? $urandom
                                                  : 32'($signed($urandom_range(0, 64)) - 32);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
